// File: rtl/mcoi_power_up_sequencer_if.sv
// Control/status bundle between the PS-facing logic and the power-up sequencer.
// Signal suffixes are from the sequencer's point of view (slave side).
interface mcoi_power_up_sequencer_if;
  logic        si5338_cfg_done_i;
  logic        gbt_pll_locked_i;
  logic        force_reset_i;
  logic        ext_pll_ready_o;
  logic        mreset_vadj_o;
  logic        sys_ready_o;
  logic [15:0] status_o;

  modport slave (
    input  si5338_cfg_done_i, gbt_pll_locked_i, force_reset_i,
    output ext_pll_ready_o, mreset_vadj_o, sys_ready_o, status_o
  );

  modport master (
    output si5338_cfg_done_i, gbt_pll_locked_i, force_reset_i,
    input  ext_pll_ready_o, mreset_vadj_o, sys_ready_o, status_o
  );
endinterface

// File: rtl/mcoi_power_up_sequencer.sv
// Board bring-up sequencer: Si5338 config -> GBT PLL lock -> settle -> release motor reset.
// Watches for lock loss, counts it, and flags over-long waits in a sticky timeout bit.
module mcoi_power_up_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SETTLE_CYCLES  = 1200000,
  parameter int unsigned HOLDOFF_CYCLES = 120000,
  parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  mcoi_power_up_sequencer_if.slave        bus
);

  localparam int unsigned MAX_A = (SETTLE_CYCLES > HOLDOFF_CYCLES) ? SETTLE_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLDOFF_LAST = CW'(HOLDOFF_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ONE          = CW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_EXT  = 3'd1,
    WAIT_LOCK = 3'd2,
    SETTLE    = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_e;

  // Reset asserts asynchronously, releases on clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [SYNC_STAGES-1:0] cfg_sync_q, lock_sync_q, force_sync_q;
  logic                   cfg, lock, force_rst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_sync_q   <= '0;
      lock_sync_q  <= '0;
      force_sync_q <= '0;
    end else begin
      cfg_sync_q   <= {cfg_sync_q[SYNC_STAGES-2:0],   bus.si5338_cfg_done_i};
      lock_sync_q  <= {lock_sync_q[SYNC_STAGES-2:0],  bus.gbt_pll_locked_i};
      force_sync_q <= {force_sync_q[SYNC_STAGES-2:0], bus.force_reset_i};
    end
  end
  assign cfg       = cfg_sync_q[SYNC_STAGES-1];
  assign lock      = lock_sync_q[SYNC_STAGES-1];
  assign force_rst = force_sync_q[SYNC_STAGES-1];

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    loss_q, loss_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      loss_q    <= loss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    wait_d  = '0;
    unique case (state_q)
      IDLE:      state_d = WAIT_EXT;
      WAIT_EXT:  if (cfg) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (!cfg)      state_d = WAIT_EXT;
        else if (lock) state_d = SETTLE;
      end
      // Lock/config loss outranks force; force pins the settle count at zero.
      SETTLE: begin
        if (!cfg || !lock)           state_d = FAULT;
        else if (force_rst)          cnt_d   = '0;
        else if (cnt_q == SETTLE_LAST) state_d = RUN;
        else                         cnt_d   = cnt_q + ONE;
      end
      RUN: begin
        if (!cfg || !lock)  state_d = FAULT;
        else if (force_rst) state_d = SETTLE;
      end
      FAULT: begin
        if (cnt_q == HOLDOFF_LAST) state_d = WAIT_EXT;
        else                       cnt_d   = cnt_q + ONE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == WAIT_EXT || state_q == WAIT_LOCK) && state_d == state_q)
      wait_d = (wait_q == TIMEOUT_LAST) ? wait_q : wait_q + ONE;
    timeout_d = timeout_q | (wait_d == TIMEOUT_LAST);

    loss_d = loss_q;
    if (state_d == FAULT && state_q != FAULT && loss_q != 8'hFF)
      loss_d = loss_q + 8'd1;
  end

  logic        ext_q, mreset_q, sys_q;
  logic [15:0] status_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q    <= 1'b0;
      mreset_q <= 1'b1;
      sys_q    <= 1'b0;
      status_q <= '0;
    end else begin
      ext_q    <= (state_q == WAIT_LOCK) || (state_q == SETTLE) || (state_q == RUN);
      mreset_q <= (state_q != RUN);
      sys_q    <= (state_q == RUN);
      status_q <= {loss_q, 4'b0000, timeout_q, state_q};
    end
  end

  assign bus.ext_pll_ready_o = ext_q;
  assign bus.mreset_vadj_o   = mreset_q;
  assign bus.sys_ready_o     = sys_q;
  assign bus.status_o        = status_q;

endmodule

// File: doc/mcoi_power_up_sequencer.md
Name: mcoi_power_up_sequencer

Overview:
- Sequences board bring-up between the external Si5338 PLL, the GBT PLL lock and the motor-driver reset line `mreset_vadj`.
- Replaces the hard-wired `si5338_ready = 1`: it generates `ext_pll_ready` for the system block and drives `mreset_vadj`.
- Monitors lock loss and reports status to the PS through the shared status register.
- Runs in the 120 MHz system clock domain.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for asynchronous inputs (min 2).
- SETTLE_CYCLES, 1200000, cycles both locks must be stable before release (10 ms at 120 MHz).
- HOLDOFF_CYCLES, 120000, cycles spent in FAULT before re-sequencing (1 ms).
- TIMEOUT_CYCLES, 12000000, cycles in a wait state before the sticky timeout flag sets (100 ms).

Ports:
- clk  input  1  120 MHz system clock
- reset_n  input  1  asynchronous, active-low reset
- si5338_cfg_done_i  input  1  PS control bit: Si5338 configured (async, synchronised here)
- gbt_pll_locked_i  input  1  GBT PLL lock (async, synchronised here)
- force_reset_i  input  1  PS control bit: hold motors in reset (async, synchronised here)
- ext_pll_ready_o  output  1  to system block: external PLL usable
- mreset_vadj_o  output  1  motor-driver reset, 1 = reset asserted
- sys_ready_o  output  1  sequence complete, motors released
- status_o  output  16  [2:0] state code, [3] timeout sticky, [7:4] reserved 0, [15:8] lock-loss count

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE, all counters 0.
  - ext_pll_ready_o=0, mreset_vadj_o=1, sys_ready_o=0, status_o=0.
  - All outputs registered.
  - Reset release is synchronised internally: 2-FF, deassert on clk.
- Input synchronisers: SYNC_STAGES flops per input. All references below are to the synchronised values (cfg, lock, force).
- States and codes:
  - IDLE(0)
  - WAIT_EXT(1)
  - WAIT_LOCK(2)
  - SETTLE(3)
  - RUN(4)
  - FAULT(5)
- Transitions:
  - IDLE → WAIT_EXT unconditionally, one cycle after reset release.
  - WAIT_EXT → WAIT_LOCK when cfg=1.
  - WAIT_LOCK → SETTLE when lock=1.
  - WAIT_LOCK → WAIT_EXT if cfg=0.
  - SETTLE: counter increments each cycle.
    - → RUN when the counter reaches SETTLE_CYCLES-1 with cfg=1, lock=1, force=0.
    - If cfg or lock drops: → FAULT.
    - If force=1: the counter holds at 0, state stays SETTLE.
  - RUN → FAULT when cfg=0 or lock=0.
  - RUN → SETTLE (counter cleared) when force=1.
  - FAULT: counts HOLDOFF_CYCLES, then → WAIT_EXT.
  - Priority when a lock drop and force occur together: FAULT wins.
- Outputs per state (registered, updated the cycle after the state change):
  - mreset_vadj_o=0 only in RUN.
  - sys_ready_o=1 only in RUN.
  - ext_pll_ready_o=1 in WAIT_LOCK, SETTLE, RUN.
- Lock-loss count:
  - 8-bit, increments on every entry to FAULT.
  - Saturates at 255 (no wrap).
  - Cleared only by reset.
- Timeout:
  - A shared wait counter runs in WAIT_EXT and WAIT_LOCK and clears on any state change.
  - Reaching TIMEOUT_CYCLES-1 sets status_o[3]; the counter stops.
  - status_o[3] is sticky until reset; the state does not change on timeout.
- Counter widths: $clog2 of the largest parameter, +1 bit. No overflow is possible.
- Latency: an input edge reaches the FSM after SYNC_STAGES cycles, and the outputs follow one cycle later.
- Glitch rule: a lock pulse shorter than SYNC_STAGES cycles may be missed. Single-cycle drops that are synchronised must trigger FAULT.

Test Plan:
- Nominal bring-up (SETTLE=16, HOLDOFF=8, TIMEOUT=64):
  - Stimulus: release reset, cfg=1 at t=10, lock=1 at t=20.
  - Response: ext_pll_ready_o rises at t=12+1. mreset_vadj_o falls and sys_ready_o rises exactly 16+SYNC+1 cycles after lock. status_o[2:0]=4.
- Lock loss in RUN:
  - Stimulus: lock=0 for 1 cycle.
  - Response: mreset_vadj_o=1 within SYNC+1 cycles, state=5, count=1. WAIT_EXT after 8 cycles, then RUN again.
- Timeout:
  - Stimulus: cfg held at 0.
  - Response: status_o[3]=1 at cycle 64 in WAIT_EXT; state stays 1. Later cfg=1 completes the sequence with bit 3 still set.
- Force reset:
  - Stimulus: force=1 while in RUN.
  - Response: state=3, mreset_vadj_o=1, counter held at 0. On force=0, RUN after 16 cycles; lock-loss count unchanged.
- Saturation and simultaneous events:
  - Stimulus: 300 lock drops.
  - Response: count=255.
  - Stimulus: lock drop and force=1 on the same cycle.
  - Response: FAULT taken.
- Async reset mid-SETTLE:
  - Stimulus: reset_n=0 while in SETTLE.
  - Response: all outputs return to reset values immediately (without a clk edge).
